// File: rtl/sar_clocked_adc_pkg.sv
// ----------------------------------------------------------------------------
// sar_adc_pkg
// Shared types and constants for the clocked multi-channel SAR ADC model:
//   - sar_state_t    : converter state encoding
//   - ADCBITS_DEF    : default resolution in bits
//   - NUMCHANNELS_DEF: default number of analog inputs
//   - chw()          : channel index width, never narrower than one bit
// ----------------------------------------------------------------------------
package sar_adc_pkg;

    localparam int ADCBITS_DEF     = 10;
    localparam int NUMCHANNELS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CONV,
        DONE
    } sar_state_t;

    // max(1, $clog2(n)): a single channel still needs a 1-bit tag.
    function automatic int chw(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sar_clocked_adc_if.sv
// ----------------------------------------------------------------------------
// sar_clocked_adc_if
// Bundles the front-end request/analog signals and the result bus of
// sar_clocked_adc.
//   master (front-end/consumer side): drives sample_req, vin_r, vref_r, vcm_r;
//                                     receives dout, dout_ch, dout_valid,
//                                     out_of_range, busy, overrun
//   slave  (converter side)         : the reverse directions
// ----------------------------------------------------------------------------
interface sar_clocked_adc_if #(
    parameter int  ADCBITS     = sar_adc_pkg::ADCBITS_DEF,
    parameter int  NUMCHANNELS = sar_adc_pkg::NUMCHANNELS_DEF,
    localparam int CHW         = sar_adc_pkg::chw(NUMCHANNELS)
);

    logic [NUMCHANNELS-1:0] sample_req;
    real                    vin_r [NUMCHANNELS];
    real                    vref_r;
    real                    vcm_r;

    logic [ADCBITS-1:0]     dout;
    logic [CHW-1:0]         dout_ch;
    logic                   dout_valid;
    logic                   out_of_range;
    logic                   busy;
    logic [NUMCHANNELS-1:0] overrun;

    modport master (
        output sample_req, vin_r, vref_r, vcm_r,
        input  dout, dout_ch, dout_valid, out_of_range, busy, overrun
    );

    modport slave (
        input  sample_req, vin_r, vref_r, vcm_r,
        output dout, dout_ch, dout_valid, out_of_range, busy, overrun
    );

endinterface

// File: rtl/sar_clocked_adc_rr_arbiter.sv
// ----------------------------------------------------------------------------
// sar_rr_arbiter
// Combinational round-robin picker: grants the first pending channel at or
// after rr_ptr, wrapping modulo NUMCHANNELS.
//   pending     : per-channel pending requests
//   rr_ptr      : highest-priority channel index for this decision
//   grant_en    : converter is ready to accept a new channel
//   grant_valid : a channel was granted
//   grant_idx   : index of the granted channel
// ----------------------------------------------------------------------------
module sar_rr_arbiter
    import sar_adc_pkg::*;
#(
    parameter int  NUMCHANNELS = NUMCHANNELS_DEF,
    localparam int CHW         = chw(NUMCHANNELS)
) (
    input  logic [NUMCHANNELS-1:0] pending,
    input  logic [CHW-1:0]         rr_ptr,
    input  logic                   grant_en,
    output logic                   grant_valid,
    output logic [CHW-1:0]         grant_idx
);

    int             sum;
    logic [CHW-1:0] idx;

    // NOTE: every output and temporary gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        sum         = 0;
        idx         = '0;
        // Walk from the farthest offset back to rr_ptr; the last hit wins,
        // which is the nearest pending channel in round-robin order.
        for (int i = NUMCHANNELS - 1; i >= 0; i--) begin
            sum = int'(rr_ptr) + i;
            idx = (sum >= NUMCHANNELS) ? CHW'(sum - NUMCHANNELS) : CHW'(sum);
            if (grant_en && pending[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/sar_clocked_adc.sv
// ----------------------------------------------------------------------------
// sar_clocked_adc
// Multi-channel clocked SAR converter: round-robin arbitration over pending
// channel requests, one result bit per clock MSB first, result returned with
// its channel tag and a one-cycle valid strobe.
//   clk   : conversion clock, all state changes on posedge
//   reset : synchronous, active-high
//   bus   : sar_clocked_adc_if.slave
//           in : sample_req, vin_r[], vref_r, vcm_r
//           out: dout, dout_ch, dout_valid, out_of_range, busy, overrun
// Build option: define SAR_ADC_CLAMP_EN to build the input range comparison
// that drives out_of_range; otherwise out_of_range is tied low.
// ----------------------------------------------------------------------------
module sar_clocked_adc
    import sar_adc_pkg::*;
#(
    parameter int  ADCBITS     = ADCBITS_DEF,
    parameter int  NUMCHANNELS = NUMCHANNELS_DEF,
    localparam int CHW         = chw(NUMCHANNELS),
    localparam int BCW         = chw(ADCBITS)
) (
    input logic              clk,
    input logic              reset,
    sar_clocked_adc_if.slave bus
);

    sar_state_t             state_q, state_d;
    logic [NUMCHANNELS-1:0] pending_q, pending_d;
    logic [NUMCHANNELS-1:0] overrun_q, overrun_d;
    logic [NUMCHANNELS-1:0] clear_mask;
    logic [CHW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [CHW-1:0]         ch_sel_q, ch_sel_d;
    logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [ADCBITS-1:0]     code_q, code_d;
    logic [ADCBITS-1:0]     dout_q, dout_d;
    logic [CHW-1:0]         dout_ch_q, dout_ch_d;
    real                    vres_q, vres_d;
    real                    vdac_q, vdac_d;
    real                    vdac_half;
`ifdef SAR_ADC_CLAMP_EN
    logic                   oor_cap_q, oor_cap_d;
    logic                   oor_q, oor_d;
`endif

    logic                   grant_en;
    logic                   grant_valid;
    logic [CHW-1:0]         grant_idx;

    // A new channel can only be taken when the converter is idle or is
    // presenting its previous result.
    assign grant_en = (state_q == IDLE) || (state_q == DONE);

    sar_rr_arbiter #(.NUMCHANNELS(NUMCHANNELS)) u_arbiter (
        .pending     (pending_q),
        .rr_ptr      (rr_ptr_q),
        .grant_en    (grant_en),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        ch_sel_d   = ch_sel_q;
        bit_cnt_d  = bit_cnt_q;
        code_d     = code_q;
        dout_d     = dout_q;
        dout_ch_d  = dout_ch_q;
        vres_d     = vres_q;
        vdac_d     = vdac_q;
        vdac_half  = vdac_q / 2.0;
        clear_mask = '0;
`ifdef SAR_ADC_CLAMP_EN
        oor_cap_d  = oor_cap_q;
        oor_d      = oor_q;
`endif

        if (grant_valid) begin
            clear_mask[grant_idx] = 1'b1;
            ch_sel_d              = grant_idx;
            rr_ptr_d              = (grant_idx == CHW'(NUMCHANNELS - 1)) ? '0 : grant_idx + 1'b1;
        end

        // The grant clears first and a same-edge request re-arms the bit, so
        // a request landing on its own grant edge is kept and not an overrun.
        pending_d = (pending_q & ~clear_mask) | bus.sample_req;
        overrun_d = overrun_q | (bus.sample_req & pending_q & ~clear_mask);

        unique case (state_q)
            IDLE: begin
                if (grant_valid) state_d = SAMPLE;
            end
            SAMPLE: begin
                vres_d    = bus.vin_r[ch_sel_q] - bus.vcm_r;
                vdac_d    = bus.vref_r - bus.vcm_r;
                bit_cnt_d = BCW'(ADCBITS - 1);
                code_d    = '0;
`ifdef SAR_ADC_CLAMP_EN
                oor_cap_d = (bus.vin_r[ch_sel_q] < bus.vcm_r) ||
                            (bus.vin_r[ch_sel_q] > bus.vref_r);
`endif
                state_d   = CONV;
            end
            CONV: begin
                vdac_d = vdac_half;
                if (vres_q > vdac_half) begin
                    code_d[bit_cnt_q] = 1'b1;
                    vres_d            = vres_q - vdac_half;
                end
                if (bit_cnt_q == '0) begin
                    // The last bit resolves on the edge that enters DONE, so
                    // the result registers take the updated code directly.
                    dout_d    = code_d;
                    dout_ch_d = ch_sel_q;
`ifdef SAR_ADC_CLAMP_EN
                    oor_d     = oor_cap_q;
`endif
                    state_d   = DONE;
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = grant_valid ? SAMPLE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            overrun_q <= '0;
            rr_ptr_q  <= '0;
            ch_sel_q  <= '0;
            bit_cnt_q <= '0;
            code_q    <= '0;
            dout_q    <= '0;
            dout_ch_q <= '0;
            vres_q    <= 0.0;
            vdac_q    <= 0.0;
`ifdef SAR_ADC_CLAMP_EN
            oor_cap_q <= 1'b0;
            oor_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            rr_ptr_q  <= rr_ptr_d;
            ch_sel_q  <= ch_sel_d;
            bit_cnt_q <= bit_cnt_d;
            code_q    <= code_d;
            dout_q    <= dout_d;
            dout_ch_q <= dout_ch_d;
            vres_q    <= vres_d;
            vdac_q    <= vdac_d;
`ifdef SAR_ADC_CLAMP_EN
            oor_cap_q <= oor_cap_d;
            oor_q     <= oor_d;
`endif
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_ch    = dout_ch_q;
    assign bus.dout_valid = (state_q == DONE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.overrun    = overrun_q;
`ifdef SAR_ADC_CLAMP_EN
    assign bus.out_of_range = oor_q;
`else
    assign bus.out_of_range = 1'b0;
`endif

endmodule

// File: tb/tb_sar_clocked_adc.sv
// ----------------------------------------------------------------------------
// tb_sar_clocked_adc
// Self-checking bench for sar_clocked_adc (ADCBITS=10, NUMCHANNELS=4).
// Expected codes come from the closed form of the strict-compare SAR:
// code = clamp(ceil(x * 2^ADCBITS) - 1), x = (vin - vcm) / (vref - vcm).
// Honours SAR_ADC_CLAMP_EN for the expected out_of_range value.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sar_clocked_adc;

    localparam int ADCBITS     = 10;
    localparam int NUMCHANNELS = 4;
    localparam int MAXCODE     = (1 << ADCBITS) - 1;
    // Request driven in cycle k is registered at edge k+1; dout_valid is seen
    // in the cycle after edge k+1+ADCBITS+2.
    localparam int LATENCY     = ADCBITS + 3;
    localparam int SPACING     = ADCBITS + 2;
`ifdef SAR_ADC_CLAMP_EN
    localparam bit CLAMP_EN    = 1'b1;
`else
    localparam bit CLAMP_EN    = 1'b0;
`endif

    typedef struct {
        int                 cyc;
        logic [ADCBITS-1:0] code;
        logic [1:0]         ch;
        logic               oor;
    } res_t;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   busy_low = 0;
    int   rd       = 0;
    int   req_cyc  = 0;
    res_t res_q[$];

    sar_clocked_adc_if #(.ADCBITS(ADCBITS), .NUMCHANNELS(NUMCHANNELS)) bus ();

    sar_clocked_adc #(.ADCBITS(ADCBITS), .NUMCHANNELS(NUMCHANNELS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Results and busy are sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        res_t r;
        if (bus.dout_valid) begin
            r.cyc  = cyc;
            r.code = bus.dout;
            r.ch   = bus.dout_ch;
            r.oor  = bus.out_of_range;
            res_q.push_back(r);
        end
        if (!bus.busy) busy_low++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int ref_code(input real vin, input real vref, input real vcm);
        real x;
        int  c;
        x = (vin - vcm) / (vref - vcm) * real'(1 << ADCBITS);
        c = $rtoi($ceil(x)) - 1;
        if (c < 0) c = 0;
        if (c > MAXCODE) c = MAXCODE;
        return c;
    endfunction

    function automatic logic ref_oor(input real vin, input real vref, input real vcm);
        return CLAMP_EN && ((vin < vcm) || (vin > vref));
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input logic [NUMCHANNELS-1:0] mask, input int hold);
        bus.sample_req = mask;
        req_cyc        = cyc;
        tick(hold);
        bus.sample_req = '0;
    endtask

    task automatic expect_result(input string tag, input int ch, input real vin,
                                 input real vref, input real vcm, input int exp_cyc);
        int   waited;
        res_t r;
        waited = 0;
        while (res_q.size() <= rd && waited < 40) begin
            tick(1);
            waited++;
        end
        check({tag, "_arrived"}, res_q.size() > rd, 1'b1);
        if (res_q.size() > rd) begin
            r = res_q[rd];
            rd++;
            check({tag, "_dout"}, r.code, ref_code(vin, vref, vcm));
            check({tag, "_ch"}, r.ch, ch);
            check({tag, "_oor"}, r.oor, ref_oor(vin, vref, vcm));
            check({tag, "_cycle"}, r.cyc, exp_cyc);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_dout"}, bus.dout, 0);
        check({tag, "_dout_ch"}, bus.dout_ch, 0);
        check({tag, "_valid"}, bus.dout_valid, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_overrun"}, bus.overrun, 0);
        check({tag, "_oor"}, bus.out_of_range, 0);
    endtask

    initial begin
        int  base;
        int  k0;
        int  ch;
        real v;

        bus.sample_req = '0;
        bus.vref_r     = 1.0;
        bus.vcm_r      = 0.0;
        for (int i = 0; i < NUMCHANNELS; i++) bus.vin_r[i] = 0.0;

        // Reset state
        reset = 1'b1;
        tick(3);
        check_idle_outputs("reset");
        reset = 1'b0;
        tick(2);
        check("idle_busy", bus.busy, 0);

        // Single conversion, mid-scale lands one code below 512
        bus.vin_r[0] = 0.5;
        pulse_req(4'b0001, 1);
        expect_result("single", 0, 0.5, 1.0, 0.0, req_cyc + LATENCY);
        tick(4);
        check("single_one_strobe", res_q.size(), 1);
        check("single_code_511", res_q[0].code, 511);
        check("single_dout_held", bus.dout, 511);

        // Code value and channel tag
        bus.vin_r[0] = 0.1;
        bus.vin_r[2] = 0.625;
        pulse_req(4'b0100, 1);
        expect_result("tag", 2, 0.625, 1.0, 0.0, req_cyc + LATENCY);

        // Range limits
        bus.vin_r[1] = 1.2;
        pulse_req(4'b0010, 1);
        expect_result("over", 1, 1.2, 1.0, 0.0, req_cyc + LATENCY);
        check("over_code_max", res_q[rd-1].code, MAXCODE);
        tick(1);
        bus.vin_r[1] = -0.1;
        pulse_req(4'b0010, 1);
        expect_result("under", 1, -0.1, 1.0, 0.0, req_cyc + LATENCY);
        check("under_code_zero", res_q[rd-1].code, 0);
        tick(1);

        // Request on its own grant edge re-arms the channel, no overrun
        bus.vin_r[1] = 0.3125;
        pulse_req(4'b0010, 2);
        k0 = req_cyc;
        expect_result("rearm_a", 1, 0.3125, 1.0, 0.0, k0 + LATENCY);
        expect_result("rearm_b", 1, 0.3125, 1.0, 0.0, k0 + LATENCY + SPACING);
        check("rearm_no_overrun", bus.overrun, 0);
        tick(2);

        // Round-robin from a fresh pointer
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        bus.vin_r[0] = 0.125;
        bus.vin_r[1] = 0.25;
        bus.vin_r[2] = 0.375;
        bus.vin_r[3] = 0.875;
        pulse_req(4'b1111, 1);
        k0 = req_cyc;
        tick(1);
        base = busy_low;
        for (int c = 0; c < NUMCHANNELS; c++)
            expect_result($sformatf("rr%0d", c), c, bus.vin_r[c], 1.0, 0.0, k0 + LATENCY + c * SPACING);
        check("rr_busy_held", busy_low - base, 0);
        check("rr_no_overrun", bus.overrun, 0);
        tick(2);

        // Overrun: req[3] twice while ch0 converts
        bus.vin_r[0] = 0.5;
        bus.vin_r[3] = 0.75;
        pulse_req(4'b0001, 1);
        k0 = req_cyc;
        tick(3);
        pulse_req(4'b1000, 2);
        check("overrun_set", bus.overrun, 4'b1000);
        expect_result("ovr_ch0", 0, 0.5, 1.0, 0.0, k0 + LATENCY);
        expect_result("ovr_ch3", 3, 0.75, 1.0, 0.0, k0 + LATENCY + SPACING);
        tick(30);
        check("overrun_single_ch3", res_q.size() - rd, 0);
        check("overrun_sticky", bus.overrun, 4'b1000);

        // Reset at CONV bit 5 with ch1 still pending
        pulse_req(4'b0001, 1);
        pulse_req(4'b0010, 1);
        tick(5);
        reset = 1'b1;
        tick(1);
        check_idle_outputs("abort");
        check("abort_no_result", res_q.size() - rd, 0);
        reset = 1'b0;
        base = busy_low;
        tick(20);
        check("abort_pending_cleared", busy_low - base, 20);
        check("abort_still_no_result", res_q.size() - rd, 0);
        pulse_req(4'b0001, 1);
        expect_result("recover", 0, 0.5, 1.0, 0.0, req_cyc + LATENCY);
        tick(1);

        // Randomised conversions with an offset reference; inputs are
        // scrambled after the sample edge to confirm they are not re-read.
        bus.vcm_r  = 0.25;
        bus.vref_r = 2.25;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < NUMCHANNELS; i++)
                bus.vin_r[i] = real'($urandom_range(0, 2600)) / 1024.0 - 0.25;
            ch = int'($urandom_range(0, NUMCHANNELS - 1));
            v  = bus.vin_r[ch];
            pulse_req(4'(1 << ch), 1);
            tick(2);
            for (int i = 0; i < NUMCHANNELS; i++)
                bus.vin_r[i] = real'($urandom_range(0, 2600)) / 1024.0 - 0.25;
            expect_result($sformatf("rand%0d", n), ch, v, 2.25, 0.25, req_cyc + LATENCY);
            tick(1);
        end
        check("rand_no_overrun", bus.overrun, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
